// File: rtl/pid_chn_scheduler.sv
// Round-robin front end for the shared multi-channel 3p3z PID controller.
// Buffers one sample per channel and limits how many channels are in flight at once.
module pid_chn_scheduler #(
   parameter int DATA_WIDTH      = 16,
   parameter int NUM_CHN         = 4,
   parameter int MAX_OUTSTANDING = 2,
   localparam int CHN_WIDTH      = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [NUM_CHN-1:0]            enable_i,
   input  logic [NUM_CHN-1:0]            smp_valid_i,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] smp_fdb_i,
   input  logic [NUM_CHN*DATA_WIDTH-1:0] smp_ref_i,
   input  logic                          tready_i,
   output logic                          data_valid_o,
   output logic [CHN_WIDTH-1:0]          data_chn_o,
   output logic [DATA_WIDTH-1:0]         data_fdb_o,
   output logic [DATA_WIDTH-1:0]         data_ref_o,
   input  logic                          u_valid_i,
   input  logic [CHN_WIDTH-1:0]          u_chn_i,
   input  logic [NUM_CHN-1:0]            overrun_clr_i,
   output logic [NUM_CHN-1:0]            pending_o,
   output logic [NUM_CHN-1:0]            inflight_o,
   output logic [NUM_CHN-1:0]            overrun_o,
   output logic                          busy_o
);

   logic [DATA_WIDTH-1:0] fdb_buf [NUM_CHN];
   logic [DATA_WIDTH-1:0] ref_buf [NUM_CHN];
   logic [CHN_WIDTH-1:0]  rr_ptr;
   logic [NUM_CHN-1:0]    eligible;
   logic [NUM_CHN-1:0]    capture;
   logic [NUM_CHN-1:0]    grant_oh;
   logic [NUM_CHN-1:0]    done_oh;
   logic                  grant_vld;
   logic [CHN_WIDTH-1:0]  grant_chn;
   logic [CHN_WIDTH-1:0]  cand;
   int                    inflight_cnt;
   int                    idx;

   assign eligible = pending_o & enable_i & ~inflight_o;
   assign capture  = smp_valid_i & enable_i;
   assign busy_o   = |{pending_o, inflight_o};

   // Descending scan so the closest eligible channel after the pointer is the last one written.
   always_comb begin
      inflight_cnt = 0;
      grant_vld    = 1'b0;
      grant_chn    = '0;
      idx          = 0;
      cand         = '0;
      for (int k = 0; k < NUM_CHN; k++) begin
         if (inflight_o[k]) inflight_cnt++;
      end
      if (tready_i && (inflight_cnt < MAX_OUTSTANDING)) begin
         for (int i = NUM_CHN; i >= 1; i--) begin
            idx  = (int'(rr_ptr) + i) % NUM_CHN;
            cand = CHN_WIDTH'(idx);
            if (eligible[cand]) begin
               grant_vld = 1'b1;
               grant_chn = cand;
            end
         end
      end
   end

   // Out-of-range result channels never match any k, so they fall out naturally.
   always_comb begin
      grant_oh = '0;
      done_oh  = '0;
      for (int k = 0; k < NUM_CHN; k++) begin
         if (grant_vld && (grant_chn == CHN_WIDTH'(k))) grant_oh[k] = 1'b1;
         if (u_valid_i && (u_chn_i == CHN_WIDTH'(k)))   done_oh[k]  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NUM_CHN; k++) begin
            fdb_buf[k] <= '0;
            ref_buf[k] <= '0;
         end
         pending_o    <= '0;
         inflight_o   <= '0;
         overrun_o    <= '0;
         rr_ptr       <= CHN_WIDTH'(NUM_CHN - 1);
         data_valid_o <= 1'b0;
         data_chn_o   <= '0;
         data_fdb_o   <= '0;
         data_ref_o   <= '0;
      end else begin
         for (int k = 0; k < NUM_CHN; k++) begin
            if (capture[k]) begin
               fdb_buf[k] <= smp_fdb_i[k*DATA_WIDTH +: DATA_WIDTH];
               ref_buf[k] <= smp_ref_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            // A capture coinciding with a grant keeps the channel pending with the fresh sample.
            if (!enable_i[k])     pending_o[k] <= 1'b0;
            else if (capture[k])  pending_o[k] <= 1'b1;
            else if (grant_oh[k]) pending_o[k] <= 1'b0;

            if (grant_oh[k])     inflight_o[k] <= 1'b1;
            else if (done_oh[k]) inflight_o[k] <= 1'b0;

            if (capture[k] && pending_o[k] && !grant_oh[k]) overrun_o[k] <= 1'b1;
            else if (overrun_clr_i[k])                      overrun_o[k] <= 1'b0;
         end
         data_valid_o <= grant_vld;
         if (grant_vld) begin
            data_chn_o <= grant_chn;
            data_fdb_o <= fdb_buf[grant_chn];
            data_ref_o <= ref_buf[grant_chn];
            rr_ptr     <= grant_chn;
         end
      end
   end

endmodule

// File: tb/tb_pid_chn_scheduler.sv
// Directed bench for pid_chn_scheduler: one instance limited to two in flight,
// a second allowing four, both fed from the same stimulus.
module tb_pid_chn_scheduler;

   logic        clk = 1'b0;
   logic        rstn;
   logic [3:0]  enable;
   logic [3:0]  smp_valid;
   logic [63:0] smp_fdb;
   logic [63:0] smp_ref;
   logic        tready;
   logic        u_valid;
   logic [1:0]  u_chn;
   logic [3:0]  overrun_clr;

   logic        dv, dv4;
   logic [1:0]  chn, chn4;
   logic [15:0] fdb, fdb4, rf, rf4;
   logic [3:0]  pend, pend4, infl, infl4, ovr, ovr4;
   logic        busy, busy4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pid_chn_scheduler #(.DATA_WIDTH(16), .NUM_CHN(4), .MAX_OUTSTANDING(2)) dut (
      .clk(clk), .rstn(rstn), .enable_i(enable), .smp_valid_i(smp_valid),
      .smp_fdb_i(smp_fdb), .smp_ref_i(smp_ref), .tready_i(tready),
      .data_valid_o(dv), .data_chn_o(chn), .data_fdb_o(fdb), .data_ref_o(rf),
      .u_valid_i(u_valid), .u_chn_i(u_chn), .overrun_clr_i(overrun_clr),
      .pending_o(pend), .inflight_o(infl), .overrun_o(ovr), .busy_o(busy)
   );

   pid_chn_scheduler #(.DATA_WIDTH(16), .NUM_CHN(4), .MAX_OUTSTANDING(4)) dut4 (
      .clk(clk), .rstn(rstn), .enable_i(enable), .smp_valid_i(smp_valid),
      .smp_fdb_i(smp_fdb), .smp_ref_i(smp_ref), .tready_i(tready),
      .data_valid_o(dv4), .data_chn_o(chn4), .data_fdb_o(fdb4), .data_ref_o(rf4),
      .u_valid_i(u_valid), .u_chn_i(u_chn), .overrun_clr_i(overrun_clr),
      .pending_o(pend4), .inflight_o(infl4), .overrun_o(ovr4), .busy_o(busy4)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int ch, input logic [15:0] f, input logic [15:0] r);
      smp_valid[ch]       = 1'b1;
      smp_fdb[ch*16 +: 16] = f;
      smp_ref[ch*16 +: 16] = r;
   endtask

   task automatic pulseReset();
      #2 rstn = 1'b0;
      #2 rstn = 1'b1;
      tick();
   endtask

   initial begin
      rstn = 1'b0; enable = 4'hF; smp_valid = '0; smp_fdb = '0; smp_ref = '0;
      tready = 1'b0; u_valid = 1'b0; u_chn = '0; overrun_clr = '0;
      #12;
      checkOutput("rst_dv",   32'(dv), 0);
      checkOutput("rst_pend", 32'(pend), 0);
      checkOutput("rst_infl", 32'(infl), 0);
      checkOutput("rst_ovr",  32'(ovr), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_data", {chn4, 14'd0, fdb}, 0);
      rstn = 1'b1;
      tick();

      // Single sample on channel 0, two-edge latency
      applyStimulus(0, 16'h0100, 16'h0200); tready = 1'b1;
      tick(); smp_valid = '0;
      checkOutput("t1_pend", 32'(pend), 32'h1);
      checkOutput("t1_lat_dv", 32'(dv), 0);
      tick();
      checkOutput("t1_dv",   32'(dv), 1);
      checkOutput("t1_chn",  32'(chn), 0);
      checkOutput("t1_fdb",  32'(fdb), 32'h0100);
      checkOutput("t1_ref",  32'(rf), 32'h0200);
      checkOutput("t1_infl", 32'(infl), 32'h1);
      tick();
      checkOutput("t1_dv_one", 32'(dv), 0);
      u_valid = 1'b1; u_chn = 2'd0;
      tick(); u_valid = 1'b0;
      checkOutput("t1_infl_clr", 32'(infl), 0);
      checkOutput("t1_busy", 32'(busy), 0);

      // Two back-to-back bursts with immediate results on the four-deep instance
      pulseReset();
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < 4; k++) applyStimulus(k, 16'(16'h1000*(b+1) + k), 16'(16'h0F00 + k));
         tick(); smp_valid = '0;
         checkOutput("t2_pend", 32'(pend4), 32'hF);
         for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("t2_dv",  32'(dv4), 1);
            checkOutput("t2_chn", 32'(chn4), 32'(k));
            checkOutput("t2_fdb", 32'(fdb4), 32'(16'h1000*(b+1) + k));
            u_valid = 1'b1; u_chn = 2'(k);
         end
         tick(); u_valid = 1'b0;
         checkOutput("t2_idle", 32'(dv4), 0);
         checkOutput("t2_busy", 32'(busy4), 0);
      end

      // Two-deep limit stalls the third grant until a result returns
      pulseReset();
      for (int k = 0; k < 4; k++) applyStimulus(k, 16'(16'h3000 + k), 16'h0);
      tick(); smp_valid = '0;
      tick();
      checkOutput("t3_chn0", {31'(chn), dv}, {31'd0, 1'b1});
      tick();
      checkOutput("t3_chn1", {31'(chn), dv}, {31'd1, 1'b1});
      checkOutput("t3_infl", 32'(infl), 32'h3);
      tick();
      checkOutput("t3_stall", 32'(dv), 0);
      checkOutput("t3_pend",  32'(pend), 32'hC);
      tick();
      checkOutput("t3_stall2", 32'(dv), 0);
      u_valid = 1'b1; u_chn = 2'd0;
      tick(); u_valid = 1'b0;
      checkOutput("t3_infl2", 32'(infl), 32'h2);
      tick();
      checkOutput("t3_chn2", {31'(chn), dv}, {31'd2, 1'b1});
      checkOutput("t3_fdb2", 32'(fdb), 32'h3002);

      // Overrun while the controller is not ready
      pulseReset();
      tready = 1'b0;
      applyStimulus(1, 16'h0011, 16'h0);
      tick();
      checkOutput("t4_ovr0", 32'(ovr), 0);
      applyStimulus(1, 16'h0022, 16'h0);
      tick(); smp_valid = '0;
      checkOutput("t4_ovr1", 32'(ovr), 32'h2);
      checkOutput("t4_noiss", 32'(dv), 0);
      tready = 1'b1;
      tick();
      checkOutput("t4_dv",  {31'(chn), dv}, {31'd1, 1'b1});
      checkOutput("t4_fdb", 32'(fdb), 32'h0022);
      tick();
      checkOutput("t4_single", 32'(dv), 0);
      checkOutput("t4_ovr_hold", 32'(ovr), 32'h2);
      overrun_clr = 4'b0010;
      tick(); overrun_clr = '0;
      checkOutput("t4_ovr_clr", 32'(ovr), 0);

      // In-flight channel blocks reissue; disabling drops a pending sample
      pulseReset();
      applyStimulus(2, 16'h0333, 16'h0);
      tick(); smp_valid = '0;
      tick();
      checkOutput("t5_dv", {31'(chn), dv}, {31'd2, 1'b1});
      applyStimulus(2, 16'h0444, 16'h0);
      tick(); smp_valid = '0;
      checkOutput("t5_pend", 32'(pend), 32'h4);
      tick();
      checkOutput("t5_block", 32'(dv), 0);
      tick();
      checkOutput("t5_block2", 32'(dv), 0);
      u_valid = 1'b1; u_chn = 2'd2;
      tick(); u_valid = 1'b0;
      checkOutput("t5_wait", 32'(dv), 0);
      tick();
      checkOutput("t5_reiss", {31'(chn), dv}, {31'd2, 1'b1});
      checkOutput("t5_fdb", 32'(fdb), 32'h0444);
      tready = 1'b0;
      applyStimulus(3, 16'h0555, 16'h0);
      tick(); smp_valid = '0;
      checkOutput("t5_pend3", 32'(pend[3]), 1);
      enable = 4'b0111;
      tick();
      checkOutput("t5_drop", 32'(pend[3]), 0);
      tready = 1'b1;
      tick();
      checkOutput("t5_noiss", 32'(dv), 0);
      tick();
      checkOutput("t5_noiss2", 32'(dv), 0);
      enable = 4'hF;

      // Asynchronous reset mid-operation
      pulseReset();
      for (int k = 0; k < 4; k++) applyStimulus(k, 16'(16'h6000 + k), 16'h0);
      tick(); smp_valid = '0;
      tick();
      tick();
      checkOutput("t6_busy", 32'(busy), 1);
      checkOutput("t6_infl", 32'(infl), 32'h3);
      #2 rstn = 1'b0;
      #1;
      checkOutput("t6_rst_dv",   32'(dv), 0);
      checkOutput("t6_rst_pend", 32'(pend), 0);
      checkOutput("t6_rst_infl", 32'(infl), 0);
      checkOutput("t6_rst_busy", 32'(busy), 0);
      checkOutput("t6_rst_data", {chn, 14'd0, fdb}, 0);
      #2 rstn = 1'b1;
      tick();
      applyStimulus(3, 16'h0ABC, 16'h0CBA);
      tick(); smp_valid = '0;
      tick();
      checkOutput("t6_dv3",  {31'(chn), dv}, {31'd3, 1'b1});
      checkOutput("t6_fdb3", 32'(fdb), 32'h0ABC);
      checkOutput("t6_ref3", 32'(rf), 32'h0CBA);
      tick();
      checkOutput("t6_only3", {28'(infl), dv}, {28'h8, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pid_chn_scheduler.md
Name: pid_chn_scheduler

Overview:
Sequences per-channel feedback/reference samples into the shared multi-channel 3p3z PID controller, which has a single data input. It buffers one sample per channel and grants the controller input round-robin when the controller is ready. It keeps at most one computation in flight per channel and reports overrun of unserviced samples. It sits between the per-motor sample sources and the controller's data_valid/data_chn/data_fdb/data_ref/tready interface, and observes u_valid/u_chn.

Parameters:
DATA_WIDTH, 16, width of feedback, reference and result data.
NUM_CHN, 4, number of channels; must be at least 1.
CHN_WIDTH, (NUM_CHN>1)?$clog2(NUM_CHN):1, derived channel index width (localparam).
MAX_OUTSTANDING, 2, maximum number of channels in flight simultaneously; range 1..NUM_CHN.

Ports:
clk  input  1  system clock, rising edge.
rstn  input  1  asynchronous active-low reset.
enable_i  input  NUM_CHN  per-channel enable.
smp_valid_i  input  NUM_CHN  per-channel new-sample strobe (1 cycle).
smp_fdb_i  input  NUM_CHN*DATA_WIDTH  packed feedback; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
smp_ref_i  input  NUM_CHN*DATA_WIDTH  packed reference, same packing as smp_fdb_i.
tready_i  input  1  controller ready to accept a sample.
data_valid_o  output  1  sample strobe to controller.
data_chn_o  output  CHN_WIDTH  channel of issued sample.
data_fdb_o  output  DATA_WIDTH  issued feedback.
data_ref_o  output  DATA_WIDTH  issued reference.
u_valid_i  input  1  controller result strobe.
u_chn_i  input  CHN_WIDTH  channel of result.
overrun_clr_i  input  NUM_CHN  clear sticky overrun bits.
pending_o  output  NUM_CHN  channel has a buffered, unissued sample.
inflight_o  output  NUM_CHN  channel issued and awaiting its result.
overrun_o  output  NUM_CHN  sticky: a buffered sample was overwritten before issue.
busy_o  output  1  OR of pending_o and inflight_o.

Behaviour:
- Reset (async, rstn=0): all outputs 0. Holding registers cleared. Round-robin pointer = NUM_CHN-1, so channel 0 wins first.
- Capture: on smp_valid_i[k] & enable_i[k], latch fdb/ref into holding register k and set pending[k]. If smp_valid_i[k] arrives while enable_i[k]=0, ignore it.
- Eligibility: chn k is eligible when pending[k] & enable_i[k] & ~inflight[k].
- Grant: grant is allowed when tready_i=1, at least one channel is eligible, and popcount(inflight) < MAX_OUTSTANDING.
  - Pick the first eligible channel searching from pointer+1 with wrap.
  - At most one grant per cycle.
- Issue: at the clock edge of a grant:
  - data_valid_o=1 for exactly 1 cycle; data_chn/fdb/ref come from the granted holding register.
  - pending[g] is cleared, inflight[g] is set, pointer = g.
  - data_chn/fdb/ref hold their last value while data_valid_o=0.
- Latency: smp_valid_i at edge E0 -> data_valid_o high after E1 at the earliest (2 edges), when tready_i=1 and no contention.
- Completion: u_valid_i clears inflight[u_chn_i]. A result for a channel that is not in flight is ignored. If u_chn_i >= NUM_CHN, ignore it.
- Simultaneous grant and completion on different channels: both take effect, so the in-flight count is unchanged.
- Completion for channel k and grant of k cannot coincide, because inflight[k] blocks eligibility of k.
- Simultaneous capture and grant, same channel: the old buffered data is issued; the new data is latched; pending[k] stays 1; no overrun.
- Overrun: capture into channel k while pending[k]=1 and k not granted that cycle -> the new data overwrites the buffer and overrun[k] is set. Set wins over a same-cycle overrun_clr_i[k].
- Disable: enable_i[k]=0 clears pending[k] on the next edge (sample dropped). inflight[k] still clears normally on its result. overrun[k] is retained.
- tready_i low: no grant; captures and overrun detection continue.

Test Plan:
- Reset, then smp_valid_i=4'b0001 with fdb=16'h0100, ref=16'h0200, tready_i=1 -> 2 edges later data_valid_o=1 for 1 cycle, chn=0, fdb=0x0100, ref=0x0200; inflight_o=0001; after u_valid_i with chn=0, inflight_o=0000 and busy_o=0.
- All 4 channels strobe together, MAX_OUTSTANDING=4, results returned immediately -> issue order 0,1,2,3 on consecutive cycles; a second burst after the last grant was 3 issues 0,1,2,3 again.
- MAX_OUTSTANDING=2, all 4 channels pending, no results -> exactly 2 issues (chn 0,1), then stall; u_valid_i chn=0 -> chn 2 issued next cycle.
- tready_i=0; chn1 strobed with fdb=0x0011, then again with fdb=0x0022 -> overrun_o[1]=1; release tready_i -> single issue with fdb=0x0022; overrun_clr_i[1] -> overrun_o[1]=0.
- chn2 is in flight and a new chn2 sample arrives -> not reissued until u_valid_i chn=2, then issued 2 edges later; drop enable_i[3] while chn3 is pending -> pending_o[3]=0 and no issue for chn3.
- Assert rstn=0 mid-operation with pending and in-flight channels -> all outputs 0 immediately (asynchronously); after release, a chn3 strobe issues as chn3 only.
